// File: rtl/alu.sv
// 8-bit ALU for the accumulator CPU datapath: x/y combined under a 3-bit opcode,
// with result, zero and carry flags registered one cycle after the operands.
module alu (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [2:0] op_i,
    output logic [7:0] r_o,
    output logic       fz_o,
    output logic       fc_o
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic [7:0] r_d, r_q;
    logic       fz_d, fz_q;
    logic       fc_d, fc_q;
    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, x_i} + {1'b0, y_i};
    // The ninth bit of the 9-bit difference is the borrow (set when x < y).
    assign diff = {1'b0, x_i} - {1'b0, y_i};

    always_comb begin
        r_d  = 8'h00;
        fc_d = 1'b0;
        case (op_e'(op_i))
            OP_ADD: begin r_d = sum[7:0];  fc_d = sum[8];  end
            OP_SUB: begin r_d = diff[7:0]; fc_d = diff[8]; end
            OP_AND: r_d = x_i & y_i;
            OP_OR:  r_d = x_i | y_i;
            OP_XOR: r_d = x_i ^ y_i;
            OP_NOT: r_d = ~x_i;
            OP_SHL: begin r_d = {x_i[6:0], 1'b0}; fc_d = x_i[7]; end
            OP_SHR: begin r_d = {1'b0, x_i[7:1]}; fc_d = x_i[0]; end
            default: begin r_d = 8'h00; fc_d = 1'b0; end
        endcase
        fz_d = (r_d == 8'h00);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q  <= 8'h00;
            fz_q <= 1'b0;
            fc_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            fz_q <= fz_d;
            fc_q <= fc_d;
        end
    end

    assign r_o  = r_q;
    assign fz_o = fz_q;
    assign fc_o = fc_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: a driver pushes expected {result, zero, carry} into a queue and a
// monitor pops one entry per clock after the capturing edge and compares.
module tb_alu;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] x_i;
    logic [7:0] y_i;
    logic [2:0] op_i;
    logic [7:0] r_o;
    logic       fz_o;
    logic       fc_o;

    int checks;
    int passed;

    logic [9:0] exp_q[$];
    logic [2:0] op_q[$];

    alu dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .x_i   (x_i),
        .y_i   (y_i),
        .op_i  (op_i),
        .r_o   (r_o),
        .fz_o  (fz_o),
        .fc_o  (fc_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // reference model, written from the opcode table with integer arithmetic
    function automatic logic [9:0] model(input int x, input int y, input int op);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
            1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            6: begin r = (x * 2) % 256; c = (x >= 128) ? 1 : 0; end
            default: begin r = x / 2; c = x % 2; end
        endcase
        return {r[7:0], (r == 0) ? 1'b1 : 1'b0, c[0]};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got r=%02h z=%0b c=%0b, required r=%02h z=%0b c=%0b",
                      name, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    endtask

    // driver: inputs change on the falling edge, captured on the next rising edge
    task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        @(negedge clk_i);
        x_i  = x;
        y_i  = y;
        op_i = op;
        exp_q.push_back(model(int'(x), int'(y), int'(op)));
        op_q.push_back(op);
    endtask

    // monitor: one result per rising edge while out of reset
    initial begin
        logic [9:0] e;
        logic [2:0] o;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = op_q.pop_front();
                check($sformatf("op%0d", o), {r_o, fz_o, fc_o}, e);
            end
        end
    end

    initial begin
        checks = 0;
        passed = 0;
        rst_ni = 1'b0;
        x_i    = 8'($urandom_range(0, 255));
        y_i    = 8'($urandom_range(0, 255));
        op_i   = 3'($urandom_range(0, 7));
        #3;
        check("reset_initial", {r_o, fz_o, fc_o}, 10'b0);
        @(posedge clk_i);
        #1;
        check("reset_held_edge", {r_o, fz_o, fc_o}, 10'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset_release", {r_o, fz_o, fc_o}, 10'b0);

        // directed cases from the opcode table and its boundaries
        apply(8'd1,   8'd1,   3'b000);
        apply(8'd255, 8'd1,   3'b000);
        apply(8'd7,   8'd3,   3'b001);
        apply(8'd2,   8'd2,   3'b001);
        apply(8'd3,   8'd4,   3'b001);
        apply(8'hF0,  8'h3C,  3'b010);
        apply(8'hF0,  8'h3C,  3'b011);
        apply(8'hF0,  8'h3C,  3'b100);
        apply(8'hF0,  8'h3C,  3'b101);
        apply(8'hF0,  8'h0F,  3'b010);
        apply(8'h81,  8'h55,  3'b110);
        apply(8'h81,  8'hAA,  3'b111);
        apply(8'h01,  8'hFF,  3'b111);
        apply(8'hFF,  8'hFF,  3'b000);
        apply(8'h00,  8'h01,  3'b001);

        // reset mid-cycle with an operation pending: the result is discarded
        apply(8'h80, 8'h80, 3'b000);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        op_q.delete();
        #1;
        check("reset_async", {r_o, fz_o, fc_o}, 10'b0);
        @(posedge clk_i);
        #1;
        check("reset_pending_dropped", {r_o, fz_o, fc_o}, 10'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset_release2", {r_o, fz_o, fc_o}, 10'b0);

        // back-to-back random vectors, opcode cycles through all eight plus random
        for (int i = 0; i < 1200; i++) begin
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  (i < 64) ? 3'(i % 8) : 3'($urandom_range(0, 7)));
        end

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_i);
        #2;
        check("queue_drained", {8'(exp_q.size()), 2'b00}, 10'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
